wb_write_arbiter: RTL and testbench
===================================

Name: wb_write_arbiter

Overview:
- Writer side of the register-file write port: merges the main-pipeline writeback and results from long-latency units (image coprocessor, divider) into a single registered (rf_wen, rf_rd, rf_data) stream that drives the register file's WEN/RD/DEST_DATA.
- Buffers coprocessor results in a small FIFO.
- Keeps a 32-entry pending-destination scoreboard that decode queries for hazard stalls.

Parameters:
- BITS, 32, data width (from common_params).
- FIFO_DEPTH, 4, coprocessor result buffer entries (power of 2, at least 2).
- STARVE_LIMIT, 8, consecutive blocked cycles before a forced drain (optional feature only).

Ports:
- clk  in  1  global clock, posedge.
- rst  in  1  synchronous, active-high reset.
- pipe_wen  in  1  main pipeline writeback valid; no backpressure.
- pipe_rd  in  5  main pipeline destination.
- pipe_data  in  BITS  main pipeline result.
- cop_valid  in  1  long-latency result valid.
- cop_rd  in  5  long-latency result destination.
- cop_data  in  BITS  long-latency result.
- cop_ready  out  1  result accepted when cop_valid & cop_ready.
- issue_valid  in  1  long-latency op issued this cycle.
- issue_rd  in  5  its destination.
- chk_rs1  in  5  decode source 1 query.
- chk_rs2  in  5  decode source 2 query.
- chk_rd  in  5  decode destination query (WAW).
- busy1  out  1  chk_rs1 pending.
- busy2  out  1  chk_rs2 pending.
- busy_rd  out  1  chk_rd pending.
- wb_stall  out  1  request pipeline freeze (optional feature; tied 0 otherwise).
- rf_wen  out  1  register file write enable.
- rf_rd  out  5  register file destination.
- rf_data  out  BITS  register file write data.
- fifo_count  out  $clog2(FIFO_DEPTH)+1  current occupancy.

Behaviour:
- Reset (rst high at posedge):
  - FIFO emptied; pending vector cleared.
  - rf_wen=0, rf_rd=0, rf_data=0, wb_stall=0, starvation counter=0.
  - cop_ready=0 while rst is high.
- cop_ready = ~full & ~rst; combinational from registered occupancy.
- Push: cop_valid & cop_ready at posedge.
  - cop_rd=0 is accepted but never written.
  - Full means no push; there is no same-cycle push-through when full.
- Write selection each posedge, for the registered outputs visible the next cycle:
  1. pipe_wen & pipe_rd!=0: rf_* <= pipe values. FIFO holds.
  2. Otherwise, FIFO non-empty: pop head; rf_wen <= (head.rd!=0); rf_rd/rf_data <= head.
  3. Otherwise: rf_wen <= 0; rf_rd/rf_data hold.
- pipe_wen with pipe_rd=0 counts as idle and does not block draining.
- Latency: result pushed at edge N is earliest popped at edge N+1; rf_wen is high during cycle N+1 to N+2, which the register file samples on that cycle's negedge.
- Push and pop in the same cycle: legal when not full; occupancy is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Scoreboard:
  - pending[issue_rd] set on issue_valid & issue_rd!=0.
  - pending[head.rd] cleared on pop.
  - Same-cycle set and clear of the same index: set wins.
  - pending[0] is always 0.
- busy1/busy2/busy_rd = pending[chk_*], combinational from the registered vector. There is no bypass of a same-cycle pop.
- Ordering contract:
  - Decode stalls on busy_rd, so no op, pipe or coprocessor, targets a pending rd.
  - Results therefore never reorder against the same rd.
  - Issue to a pending rd is illegal and flagged by assertion.

Optional Feature:
- WB_STARVE_GUARD_EN defined:
  - Counter increments each cycle the FIFO is non-empty and a pop is blocked by a pipe write; it resets to 0 on any pop.
  - When the counter reaches STARVE_LIMIT, wb_stall <= 1.
  - While wb_stall=1, the FIFO head has priority over pipe_wen. The pipeline must hold pipe_wen=0; a pipe write presented anyway is ignored and flagged by assertion.
  - wb_stall <= 0 on the edge that pops.
- Undefined: wb_stall tied 0, no counter, pure pipe priority.

Decomposition:
- Package wb_pkg holds:
  - wb_entry_t, a packed struct of rd[4:0] and data[BITS-1:0].
  - WB_FIFO_DEPTH default.
  - WB_STARVE_LIMIT default.
- BITS comes from common_params.
- One sub-module, wb_result_fifo: synchronous FIFO of wb_entry_t with push/pop, full/empty and count.
- Arbitration, scoreboard and guard live in the top.

Test Plan:
- Reset mid-drain: 3 entries queued, assert rst for 1 cycle. Required: fifo_count=0, rf_wen=0, pending=0, cop_ready=0 during rst and 1 after release.
- Pipe only: pipe_wen=1, rd=5, data=0xDEADBEEF at edge N. Required: rf_wen=1, rf_rd=5, rf_data=0xDEADBEEF in cycle N+1; pipe_rd=0 gives rf_wen=0.
- Coprocessor path:
  - issue_valid with issue_rd=7 gives busy1=1 for chk_rs1=7.
  - Push cop_rd=7, data=0x12345678 with pipe idle. Required: rf_wen for rd 7 two cycles after push; busy1=0 the cycle after pop.
- Collision: FIFO holds rd=9; pipe writes rd=3 for 2 cycles. Required: rd 3 written twice, then rd 9 on the first idle cycle; FIFO order preserved.
- Full: push 4 entries with pipe continuously busy. Required: cop_ready=0 and fifo_count=4; a 5th cop_valid is held, not lost; it is accepted the cycle after the first pop.
- WB_STARVE_GUARD_EN, STARVE_LIMIT=8: pipe writes every cycle with the FIFO non-empty. Required: wb_stall=1 after 8 blocked cycles, head popped on the next edge, wb_stall=0 after it.

Source files
------------

// File: rtl/wb_pkg.sv
// Shared types and defaults for the register-file writeback arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package wb_pkg;

    // Datapath width; mirrors BITS from common_params.
    localparam int WB_BITS         = 32;
    localparam int WB_FIFO_DEPTH   = 4;
    localparam int WB_STARVE_LIMIT = 8;

    // One buffered long-latency result: destination register plus data.
    typedef struct packed {
        logic [4:0]         rd;
        logic [WB_BITS-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/wb_result_fifo.sv
// Synchronous FIFO of wb_entry_t holding coprocessor/divider results awaiting the write port.
// Latency: an entry pushed at edge N is visible at head_dat after edge N and can be popped at edge N+1.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module wb_result_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = WB_FIFO_DEPTH,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push,
    input  wb_entry_t push_dat,
    input  logic      pop,
    output wb_entry_t head_dat,
    output logic      full,
    output logic      empty,
    output logic [AW:0] count
);

    wb_entry_t         mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign head_dat = mem[rd_ptr];

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage write; contents need no reset since occupancy gates every read.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Merges pipe writeback and buffered long-latency results onto one registered RF write port; tracks pending dests.
// Latency: one edge from selection to rf_*; a pushed result pops no earlier than the following edge.
// Backpressure: cop_ready drops when the FIFO is full; with WB_STARVE_GUARD_EN, wb_stall freezes the pipe after STARVE_LIMIT blocked cycles.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int BITS         = WB_BITS,
    parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
    parameter int STARVE_LIMIT = WB_STARVE_LIMIT
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        pipe_wen,
    input  logic [4:0]                  pipe_rd,
    input  logic [BITS-1:0]             pipe_data,
    input  logic                        cop_valid,
    input  logic [4:0]                  cop_rd,
    input  logic [BITS-1:0]             cop_data,
    output logic                        cop_ready,
    input  logic                        issue_valid,
    input  logic [4:0]                  issue_rd,
    input  logic [4:0]                  chk_rs1,
    input  logic [4:0]                  chk_rs2,
    input  logic [4:0]                  chk_rd,
    output logic                        busy1,
    output logic                        busy2,
    output logic                        busy_rd,
    output logic                        wb_stall,
    output logic                        rf_wen,
    output logic [4:0]                  rf_rd,
    output logic [BITS-1:0]             rf_data,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    wb_entry_t   push_dat;
    wb_entry_t   head;
    logic        full;
    logic        empty;
    logic        push;
    logic        pop;
    logic        pipe_req;
    logic        pipe_sel;
    logic [31:0] pending;
    logic [31:0] pending_nxt;

    assign cop_ready     = ~full & ~rst;
    assign push          = cop_valid & cop_ready;
    assign push_dat.rd   = cop_rd;
    assign push_dat.data = cop_data;

    // A pipe write to r0 is treated as idle so it never blocks draining.
    assign pipe_req = pipe_wen & (pipe_rd != 5'd0);

`ifdef WB_STARVE_GUARD_EN
    localparam int CW = $clog2(STARVE_LIMIT + 1);

    logic [CW-1:0] starve_cnt;
    logic          stall_q;

    assign wb_stall = stall_q;
    // While stalled the FIFO head wins and any pipe write is dropped.
    assign pipe_sel = pipe_req & ~stall_q;

    // Starvation counter: count blocked pops, raise stall at the limit, clear both on any pop.
    always_ff @(posedge clk) begin
        if (rst) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else if (pop) begin
            starve_cnt <= '0;
            stall_q    <= 1'b0;
        end else if (!empty && pipe_req) begin
            starve_cnt <= starve_cnt + CW'(1);
            if (starve_cnt + CW'(1) == CW'(STARVE_LIMIT)) stall_q <= 1'b1;
        end
    end

    a_no_pipe_during_stall: assert property (@(posedge clk) disable iff (rst)
        !(stall_q && pipe_req));
`else
    assign wb_stall = 1'b0;
    assign pipe_sel = pipe_req;
`endif

    assign pop = ~empty & ~pipe_sel;

    wb_result_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .push_dat (push_dat),
        .pop      (pop),
        .head_dat (head),
        .full     (full),
        .empty    (empty),
        .count    (fifo_count)
    );

    // Registered write port: pipe first, else FIFO head, else idle holding rd/data.
    always_ff @(posedge clk) begin
        if (rst) begin
            rf_wen  <= 1'b0;
            rf_rd   <= '0;
            rf_data <= '0;
        end else if (pipe_sel) begin
            rf_wen  <= 1'b1;
            rf_rd   <= pipe_rd;
            rf_data <= pipe_data;
        end else if (pop) begin
            rf_wen  <= (head.rd != 5'd0);
            rf_rd   <= head.rd;
            rf_data <= head.data;
        end else begin
            rf_wen  <= 1'b0;
        end
    end

    // Scoreboard update: clear on pop first, then set on issue so a same-index set wins; r0 never pending.
    always_comb begin
        pending_nxt = pending;
        if (pop) pending_nxt[head.rd] = 1'b0;
        if (issue_valid && issue_rd != 5'd0) pending_nxt[issue_rd] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    // Scoreboard register.
    always_ff @(posedge clk) begin
        if (rst) pending <= '0;
        else     pending <= pending_nxt;
    end

    // Hazard queries read the registered vector; a same-cycle pop is not bypassed.
    assign busy1   = pending[chk_rs1];
    assign busy2   = pending[chk_rs2];
    assign busy_rd = pending[chk_rd];

    a_issue_not_pending: assert property (@(posedge clk) disable iff (rst)
        !(issue_valid && issue_rd != 5'd0 && pending[issue_rd]));

    a_param_sane: assert property (@(posedge clk)
        (FIFO_DEPTH >= 2) && ((FIFO_DEPTH & (FIFO_DEPTH - 1)) == 0) && (STARVE_LIMIT >= 1));

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: directed scenarios plus randomized traffic against a queue-level reference model.
// Latency: inputs driven and outputs sampled on the falling edge.
// Backpressure: the bench honours cop_ready, issue/pending and (when enabled) wb_stall rules.
module tb_wb_write_arbiter;

    localparam int DEPTH = 4;
    localparam int LIMIT = 8;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          pipe_wen;
    logic [4:0]    pipe_rd;
    logic [31:0]   pipe_data;
    logic          cop_valid;
    logic [4:0]    cop_rd;
    logic [31:0]   cop_data;
    logic          cop_ready;
    logic          issue_valid;
    logic [4:0]    issue_rd;
    logic [4:0]    chk_rs1, chk_rs2, chk_rd;
    logic          busy1, busy2, busy_rd, wb_stall, rf_wen;
    logic [4:0]    rf_rd;
    logic [31:0]   rf_data;
    logic [CW-1:0] fifo_count;

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model: result queue, pending set, last RF write, starvation state.
    logic [36:0] mq[$];
    logic [31:0] m_pend;
    logic        m_wen;
    logic [4:0]  m_rd;
    logic [31:0] m_data;
    logic        m_stall;
    int          m_cnt;

    always #5 clk = ~clk;

    wb_write_arbiter #(.BITS(32), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .pipe_wen(pipe_wen), .pipe_rd(pipe_rd), .pipe_data(pipe_data),
        .cop_valid(cop_valid), .cop_rd(cop_rd), .cop_data(cop_data), .cop_ready(cop_ready),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .chk_rs1(chk_rs1), .chk_rs2(chk_rs2), .chk_rd(chk_rd),
        .busy1(busy1), .busy2(busy2), .busy_rd(busy_rd), .wb_stall(wb_stall),
        .rf_wen(rf_wen), .rf_rd(rf_rd), .rf_data(rf_data), .fifo_count(fifo_count)
    );

    task automatic idle_inputs();
        pipe_wen = 0; pipe_rd = 0; pipe_data = 0;
        cop_valid = 0; cop_rd = 0; cop_data = 0;
        issue_valid = 0; issue_rd = 0;
    endtask

    // Advance the model by one edge using the current inputs, then move to the next falling edge.
    task automatic tick();
        int          sz;
        bit          push, preq, psel, popq;
        logic [36:0] hd;
        sz   = mq.size();
        push = cop_valid && (sz < DEPTH) && !rst;
        preq = pipe_wen && (pipe_rd != 0);
`ifdef WB_STARVE_GUARD_EN
        psel = preq && !m_stall;
`else
        psel = preq;
`endif
        popq = !psel && (sz > 0);
        if (rst) begin
            mq.delete(); m_pend = 0; m_wen = 0; m_rd = 0; m_data = 0; m_stall = 0; m_cnt = 0;
        end else begin
            if (psel) begin
                m_wen = 1; m_rd = pipe_rd; m_data = pipe_data;
            end else if (popq) begin
                hd = mq.pop_front();
                m_wen = (hd[36:32] != 0); m_rd = hd[36:32]; m_data = hd[31:0];
                m_pend[hd[36:32]] = 1'b0;
            end else begin
                m_wen = 0;
            end
            if (issue_valid && issue_rd != 0) m_pend[issue_rd] = 1'b1;
            m_pend[0] = 1'b0;
            if (push) mq.push_back({cop_rd, cop_data});
`ifdef WB_STARVE_GUARD_EN
            if (popq) begin
                m_cnt = 0; m_stall = 0;
            end else if (sz > 0 && preq) begin
                m_cnt++;
                if (m_cnt == LIMIT) m_stall = 1;
            end
`endif
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic test_reset();
        idle_inputs();
        rst = 1;
        tick();
        n_cmp++; if (cop_ready !== 1'b0) begin n_bad++; $display("FAIL reset_cop_ready: got %b want 0", cop_ready); end
        n_cmp++; if (fifo_count !== 0) begin n_bad++; $display("FAIL reset_count: got %0d want 0", fifo_count); end
        n_cmp++; if ({rf_wen, rf_rd, rf_data} !== 38'd0) begin n_bad++; $display("FAIL reset_rf: got %b/%0d/%h want 0/0/0", rf_wen, rf_rd, rf_data); end
        n_cmp++; if (wb_stall !== 1'b0) begin n_bad++; $display("FAIL reset_stall: got %b want 0", wb_stall); end
        rst = 0;
        #1;
        n_cmp++; if (cop_ready !== 1'b1) begin n_bad++; $display("FAIL release_cop_ready: got %b want 1", cop_ready); end
    endtask

    task automatic test_pipe_only();
        idle_inputs();
        pipe_wen = 1; pipe_rd = 5; pipe_data = 32'hDEADBEEF;
        tick();
        n_cmp++; if ({rf_wen, rf_rd, rf_data} !== {1'b1, 5'd5, 32'hDEADBEEF}) begin n_bad++; $display("FAIL pipe_write: got %b/%0d/%h want 1/5/deadbeef", rf_wen, rf_rd, rf_data); end
        pipe_rd = 0; pipe_data = 32'h0BADF00D;
        tick();
        n_cmp++; if ({rf_wen, rf_rd, rf_data} !== {1'b0, 5'd5, 32'hDEADBEEF}) begin n_bad++; $display("FAIL pipe_r0_idle: got %b/%0d/%h want 0/5/deadbeef", rf_wen, rf_rd, rf_data); end
        idle_inputs();
    endtask

    task automatic test_cop_path();
        idle_inputs();
        chk_rs1 = 7; chk_rs2 = 8; chk_rd = 7;
        issue_valid = 1; issue_rd = 7;
        tick();
        issue_valid = 0;
        n_cmp++; if ({busy1, busy2, busy_rd} !== 3'b101) begin n_bad++; $display("FAIL issue_busy: got %b want 101", {busy1, busy2, busy_rd}); end
        cop_valid = 1; cop_rd = 7; cop_data = 32'h12345678;
        tick();
        cop_valid = 0;
        n_cmp++; if ({fifo_count, rf_wen, busy1} !== {3'd1, 1'b0, 1'b1}) begin n_bad++; $display("FAIL cop_pushed: got cnt=%0d wen=%b busy=%b want 1/0/1", fifo_count, rf_wen, busy1); end
        tick();
        n_cmp++; if ({rf_wen, rf_rd, rf_data} !== {1'b1, 5'd7, 32'h12345678}) begin n_bad++; $display("FAIL cop_write: got %b/%0d/%h want 1/7/12345678", rf_wen, rf_rd, rf_data); end
        n_cmp++; if ({busy1, fifo_count} !== {1'b0, 3'd0}) begin n_bad++; $display("FAIL cop_cleared: got busy=%b cnt=%0d want 0/0", busy1, fifo_count); end
        tick();
        n_cmp++; if (rf_wen !== 1'b0) begin n_bad++; $display("FAIL cop_after: got %b want 0", rf_wen); end
    endtask

    task automatic test_collision();
        logic [4:0] seq_rd [4];
        seq_rd = '{5'd3, 5'd3, 5'd9, 5'd10};
        idle_inputs();
        chk_rd = 9;
        issue_valid = 1; issue_rd = 9; tick();
        issue_rd = 10; tick();
        issue_valid = 0;
        pipe_wen = 1; pipe_rd = 3;
        for (int i = 0; i < 4; i++) begin
            if (i < 2) begin
                pipe_data = 32'h33330000 + i;
                cop_valid = 1; cop_rd = (i == 0) ? 5'd9 : 5'd10; cop_data = 32'hAAAA0000 + cop_rd;
            end else begin
                pipe_wen = 0; cop_valid = 0;
            end
            tick();
            n_cmp++; if ({rf_wen, rf_rd} !== {1'b1, seq_rd[i]}) begin n_bad++; $display("FAIL collision_order%0d: got %b/%0d want 1/%0d", i, rf_wen, rf_rd, seq_rd[i]); end
            if (i == 1) begin
                n_cmp++; if ({fifo_count, busy_rd} !== {3'd2, 1'b1}) begin n_bad++; $display("FAIL collision_held: got cnt=%0d busy=%b want 2/1", fifo_count, busy_rd); end
            end
            if (i == 3) begin
                n_cmp++; if (rf_data !== 32'hAAAA000A) begin n_bad++; $display("FAIL collision_data: got %h want aaaa000a", rf_data); end
            end
        end
    endtask

    task automatic test_full();
        logic [4:0] exp_rd [4];
        exp_rd = '{5'd12, 5'd13, 5'd14, 5'd15};
        idle_inputs();
        pipe_wen = 1; pipe_rd = 2;
        for (int k = 0; k < 4; k++) begin
            pipe_data = k; cop_valid = 1; cop_rd = 5'(11 + k); cop_data = 32'hC0 + k;
            tick();
        end
        n_cmp++; if ({fifo_count, cop_ready} !== {3'd4, 1'b0}) begin n_bad++; $display("FAIL full_state: got cnt=%0d rdy=%b want 4/0", fifo_count, cop_ready); end
        cop_rd = 15; cop_data = 32'hF5;
        tick();
        n_cmp++; if ({fifo_count, cop_ready} !== {3'd4, 1'b0}) begin n_bad++; $display("FAIL full_held: got cnt=%0d rdy=%b want 4/0", fifo_count, cop_ready); end
        pipe_wen = 0;
        tick();
        n_cmp++; if ({rf_rd, fifo_count, cop_ready} !== {5'd11, 3'd3, 1'b1}) begin n_bad++; $display("FAIL full_first_pop: got rd=%0d cnt=%0d rdy=%b want 11/3/1", rf_rd, fifo_count, cop_ready); end
        for (int k = 0; k < 4; k++) begin
            tick();
            cop_valid = 0;
            n_cmp++; if ({rf_wen, rf_rd} !== {1'b1, exp_rd[k]}) begin n_bad++; $display("FAIL full_drain%0d: got %b/%0d want 1/%0d", k, rf_wen, rf_rd, exp_rd[k]); end
        end
        n_cmp++; if ({rf_data, fifo_count} !== {32'hF5, 3'd0}) begin n_bad++; $display("FAIL full_fifth: got %h cnt=%0d want f5/0", rf_data, fifo_count); end
    endtask

    task automatic test_reset_mid_drain();
        idle_inputs();
        chk_rs1 = 20; chk_rs2 = 21; chk_rd = 22;
        issue_valid = 1; issue_rd = 20; tick();
        issue_rd = 21; tick();
        issue_valid = 0;
        pipe_wen = 1; pipe_rd = 4;
        for (int k = 0; k < 3; k++) begin
            cop_valid = 1; cop_rd = 5'(20 + k); cop_data = k;
            tick();
        end
        idle_inputs();
        tick();
        rst = 1;
        #1;
        n_cmp++; if (cop_ready !== 1'b0) begin n_bad++; $display("FAIL mid_rst_ready: got %b want 0", cop_ready); end
        tick();
        n_cmp++; if ({fifo_count, rf_wen, busy1, busy2, busy_rd, cop_ready} !== 8'd0) begin n_bad++; $display("FAIL mid_rst_state: got cnt=%0d wen=%b busy=%b%b%b rdy=%b want all 0", fifo_count, rf_wen, busy1, busy2, busy_rd, cop_ready); end
        rst = 0;
        tick();
        n_cmp++; if ({fifo_count, rf_wen, cop_ready} !== {3'd0, 1'b0, 1'b1}) begin n_bad++; $display("FAIL mid_rst_after: got cnt=%0d wen=%b rdy=%b want 0/0/1", fifo_count, rf_wen, cop_ready); end
    endtask

`ifdef WB_STARVE_GUARD_EN
    task automatic test_starve();
        idle_inputs();
        pipe_wen = 1; pipe_rd = 6; pipe_data = 32'h66;
        cop_valid = 1; cop_rd = 21; cop_data = 32'h21212121;
        tick();
        cop_valid = 0;
        for (int i = 1; i <= LIMIT; i++) begin
            pipe_data = $urandom;
            tick();
            n_cmp++; if ({wb_stall, rf_rd} !== {(i == LIMIT), 5'd6}) begin n_bad++; $display("FAIL starve_cycle%0d: got stall=%b rd=%0d want %b/6", i, wb_stall, rf_rd, (i == LIMIT)); end
        end
        pipe_wen = 0;
        tick();
        n_cmp++; if ({rf_wen, rf_rd, rf_data, wb_stall, fifo_count} !== {1'b1, 5'd21, 32'h21212121, 1'b0, 3'd0}) begin n_bad++; $display("FAIL starve_drain: got %b/%0d/%h stall=%b cnt=%0d want 1/21/21212121/0/0", rf_wen, rf_rd, rf_data, wb_stall, fifo_count); end
    endtask
`endif

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            rst         = ($urandom_range(0, 49) == 0);
            pipe_wen    = $urandom_range(0, 1);
            pipe_rd     = $urandom;
            pipe_data   = $urandom;
            if (m_pend[pipe_rd] || m_stall) pipe_wen = 0;
            cop_valid   = ($urandom_range(0, 9) < 4);
            cop_rd      = $urandom;
            cop_data    = $urandom;
            issue_valid = ($urandom_range(0, 9) < 3);
            issue_rd    = $urandom;
            if (m_pend[issue_rd]) issue_valid = 0;
            chk_rs1 = $urandom; chk_rs2 = $urandom; chk_rd = $urandom;
            tick();
            n_cmp++; if (rf_wen !== m_wen) begin n_bad++; $display("FAIL rnd%0d_wen: got %b want %b", c, rf_wen, m_wen); end
            n_cmp++; if (rf_rd !== m_rd) begin n_bad++; $display("FAIL rnd%0d_rd: got %0d want %0d", c, rf_rd, m_rd); end
            n_cmp++; if (rf_data !== m_data) begin n_bad++; $display("FAIL rnd%0d_data: got %h want %h", c, rf_data, m_data); end
            n_cmp++; if (fifo_count !== CW'(mq.size())) begin n_bad++; $display("FAIL rnd%0d_count: got %0d want %0d", c, fifo_count, mq.size()); end
            n_cmp++; if (cop_ready !== (mq.size() < DEPTH && !rst)) begin n_bad++; $display("FAIL rnd%0d_ready: got %b want %b", c, cop_ready, (mq.size() < DEPTH && !rst)); end
            n_cmp++; if ({busy1, busy2, busy_rd} !== {m_pend[chk_rs1], m_pend[chk_rs2], m_pend[chk_rd]}) begin n_bad++; $display("FAIL rnd%0d_busy: got %b%b%b want %b%b%b", c, busy1, busy2, busy_rd, m_pend[chk_rs1], m_pend[chk_rs2], m_pend[chk_rd]); end
            n_cmp++; if (wb_stall !== m_stall) begin n_bad++; $display("FAIL rnd%0d_stall: got %b want %b", c, wb_stall, m_stall); end
        end
        rst = 0;
        idle_inputs();
    endtask

    initial begin
        idle_inputs();
        chk_rs1 = 0; chk_rs2 = 0; chk_rd = 0;
        rst = 1;
        m_pend = 0; m_wen = 0; m_rd = 0; m_data = 0; m_stall = 0; m_cnt = 0;
        tick();
        test_reset();
        test_pipe_only();
        test_cop_path();
        test_collision();
        test_full();
        test_reset_mid_drain();
`ifdef WB_STARVE_GUARD_EN
        test_starve();
`endif
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
